// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS period encoding and island timing constants
package hdmi_pkg;

  typedef enum logic [2:0] {
    CTRL           = 3'd0,
    VIDEO_PREAMBLE = 3'd1,
    VIDEO_GUARD    = 3'd2,
    VIDEO          = 3'd3,
    DI_PREAMBLE    = 3'd4,
    DI_GUARD       = 3'd5,
    DI_PACKET      = 3'd6
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_LGUARD = 3'd2,
    ST_PKT    = 3'd3,
    ST_TGUARD = 3'd4
  } island_state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int CTRL_MIN     = 12;

endpackage

// File: rtl/hdmi_pkt_arbiter.sv
// rtl/hdmi_pkt_arbiter.sv - packet slot arbiter; HDMI_SCHED_RR_EN selects round-robin,
// otherwise fixed priority with lowest index winning.
module hdmi_pkt_arbiter #(
  parameter int NUM_SOURCES = 4,
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
`ifdef HDMI_SCHED_RR_EN
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   advance_i,
`endif
  input  logic [NUM_SOURCES-1:0] req_i,
  output logic [SW-1:0]          win_o
);

`ifdef HDMI_SCHED_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // ptr_q is the first index searched; it moves past each winner
  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (!found && req_i[SW'(idx)]) begin
        found = 1'b1;
        win_o = SW'(idx);
      end
    end
    ptr_d = (win_o == SW'(NUM_SOURCES - 1)) ? '0 : win_o + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_o = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req_i[SW'(i)]) win_o = SW'(i);
    end
  end
`endif

endmodule

// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - per-pixel TMDS period sequencer and data-island packet scheduler
// (arbitration policy set by HDMI_SCHED_RR_EN inside hdmi_pkt_arbiter).
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int BIT_WIDTH   = 10,
  parameter int BIT_HEIGHT  = 10,
  parameter int NUM_SOURCES = 4,
  parameter int MAX_PACKETS = 18,
  parameter int ISLAND_X    = 10
) (
  input  logic                           clk_pixel,
  input  logic                           rst_n,
  input  logic [BIT_WIDTH-1:0]           cx,
  input  logic [BIT_HEIGHT-1:0]          cy,
  input  logic [BIT_WIDTH-1:0]           screen_start_x,
  input  logic [BIT_HEIGHT-1:0]          screen_start_y,
  input  logic [NUM_SOURCES-1:0]         pkt_req,
  output logic [NUM_SOURCES-1:0]         pkt_grant,
  output logic [$clog2(NUM_SOURCES)-1:0] pkt_sel,
  output logic [4:0]                     sub_count,
  output logic [2:0]                     mode
);

  localparam int SW       = $clog2(NUM_SOURCES);
  localparam int CW       = $clog2(MAX_PACKETS + 1);
  localparam int XW       = BIT_WIDTH + 1;
  localparam int OVERHEAD = PREAMBLE_LEN + 2 * GUARD_LEN + CTRL_MIN;

  island_state_t          state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [4:0]             sub_q, sub_d;
  logic [CW-1:0]          pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]          budget_q, budget_d, budget_new;
  mode_t                  mode_q, mode_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  logic [SW-1:0]          sel_q, sel_d, win;
  logic [XW-1:0]          cx_w, ssx_w, span;
  logic                   take, grant_fire;

  assign cx_w  = {1'b0, cx};
  assign ssx_w = {1'b0, screen_start_x};

  // Packets that fit between the island start and ssx while leaving CTRL_MIN control pixels
  always_comb begin
    span       = '0;
    budget_new = '0;
    if (ssx_w >= XW'(ISLAND_X + OVERHEAD + PACKET_LEN)) begin
      span       = (ssx_w - XW'(ISLAND_X + OVERHEAD)) >> $clog2(PACKET_LEN);
      budget_new = (span > XW'(MAX_PACKETS)) ? CW'(MAX_PACKETS) : CW'(span);
    end
    budget_d = (cx == '0) ? budget_new : budget_q;
  end

  // state_q describes the previous pixel; state_d is the period of the pixel on cx now
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    sub_d     = '0;
    pkt_cnt_d = pkt_cnt_q;
    take      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cx == BIT_WIDTH'(ISLAND_X) && budget_q != '0 && |pkt_req) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (cnt_q == 3'(PREAMBLE_LEN - 1)) state_d = ST_LGUARD;
        else cnt_d = cnt_q + 3'd1;
      end
      ST_LGUARD: begin
        if (cnt_q == 3'(GUARD_LEN - 1)) begin
          state_d   = ST_PKT;
          take      = 1'b1;
          pkt_cnt_d = CW'(1);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PKT: begin
        if (sub_q == 5'(PACKET_LEN - 1)) begin
          if (pkt_cnt_q < budget_q && |pkt_req) begin
            take      = 1'b1;
            pkt_cnt_d = pkt_cnt_q + CW'(1);
          end else begin
            state_d = ST_TGUARD;
          end
        end else begin
          sub_d = sub_q + 5'd1;
        end
      end
      ST_TGUARD: begin
        if (cnt_q == 3'(GUARD_LEN - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_fire = take & (|pkt_req);

  always_comb begin
    grant_d = '0;
    sel_d   = sel_q;
    if (grant_fire) begin
      grant_d[win] = 1'b1;
      sel_d        = win;
    end
  end

  always_comb begin
    mode_d = CTRL;
    case (state_d)
      ST_PRE:               mode_d = DI_PREAMBLE;
      ST_LGUARD, ST_TGUARD: mode_d = DI_GUARD;
      ST_PKT:               mode_d = DI_PACKET;
      default: begin
        if (cy >= screen_start_y) begin
          if (cx_w >= ssx_w)                                         mode_d = VIDEO;
          else if (cx_w + XW'(GUARD_LEN) >= ssx_w)                   mode_d = VIDEO_GUARD;
          else if (cx_w + XW'(PREAMBLE_LEN + GUARD_LEN) >= ssx_w)    mode_d = VIDEO_PREAMBLE;
        end
      end
    endcase
  end

  hdmi_pkt_arbiter #(.NUM_SOURCES(NUM_SOURCES)) u_arb (
`ifdef HDMI_SCHED_RR_EN
    .clk_i     (clk_pixel),
    .rst_ni    (rst_n),
    .advance_i (grant_fire),
`endif
    .req_i     (pkt_req),
    .win_o     (win)
  );

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sub_q     <= '0;
      pkt_cnt_q <= '0;
      budget_q  <= '0;
      mode_q    <= CTRL;
      grant_q   <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      pkt_cnt_q <= pkt_cnt_d;
      budget_q  <= budget_d;
      mode_q    <= mode_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
    end
  end

  assign pkt_grant = grant_q;
  assign pkt_sel   = sel_q;
  assign sub_count = sub_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb/tb_hdmi_island_scheduler.sv - directed bench for hdmi_island_scheduler (both HDMI_SCHED_RR_EN builds)
module tb_hdmi_island_scheduler;

  localparam int M_CTRL = 0, M_VP = 1, M_VG = 2, M_V = 3, M_DIP = 4, M_DIG = 5, M_DIK = 6;
  localparam int LINE = 800;

  logic       clk_pixel = 1'b0;
  logic       rst_n;
  logic [9:0] cx, cy, ssx, ssy;
  logic [3:0] pkt_req;
  logic [3:0] pkt_grant;
  logic [1:0] pkt_sel;
  logic [4:0] sub_count;
  logic [2:0] mode;

  int errors = 0;
  int checks = 0;
  int mode_log[LINE];
  int sub_log[LINE];
  int sel_log[LINE];
  int exp_mode[LINE];
  int g_x[$];
  int g_i[$];

  hdmi_island_scheduler dut (
    .clk_pixel      (clk_pixel),
    .rst_n          (rst_n),
    .cx             (cx),
    .cy             (cy),
    .screen_start_x (ssx),
    .screen_start_y (ssy),
    .pkt_req        (pkt_req),
    .pkt_grant      (pkt_grant),
    .pkt_sel        (pkt_sel),
    .sub_count      (sub_count),
    .mode           (mode)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    if ($countones(g) != 1) return -1;
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic step(input int x, input int y);
    @(negedge clk_pixel);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
    mode_log[x] = int'(mode);
    sub_log[x]  = int'(sub_count);
    sel_log[x]  = int'(pkt_sel);
    if (pkt_grant != 4'b0000) begin
      g_x.push_back(x);
      g_i.push_back(onehot_idx(pkt_grant));
    end
  endtask

  task automatic run_range(input int y, input int lo, input int hi, input int drop_x);
    for (int x = lo; x <= hi; x++) begin
      if (x == drop_x) pkt_req = 4'b0000;
      step(x, y);
    end
  endtask

  task automatic new_line();
    g_x.delete();
    g_i.delete();
    for (int x = 0; x < LINE; x++) begin
      mode_log[x] = -1;
      exp_mode[x] = M_CTRL;
    end
  endtask

  task automatic fill(input int lo, input int hi, input int v);
    for (int x = lo; x <= hi; x++) exp_mode[x] = v;
  endtask

  task automatic exp_island(input int n);
    fill(10, 17, M_DIP);
    fill(18, 19, M_DIG);
    fill(20, 20 + 32 * n - 1, M_DIK);
    fill(20 + 32 * n, 21 + 32 * n, M_DIG);
  endtask

  task automatic cmp_line(input string tag);
    int bad;
    bad = -1;
    for (int x = 0; x < LINE; x++) begin
      if (bad < 0 && mode_log[x] !== exp_mode[x]) bad = x;
    end
    checks++;
    assert (bad == -1) else begin
      errors++;
      $error("FAIL %s cx=%0d observed mode=%0d expected mode=%0d", tag, bad, mode_log[bad], exp_mode[bad]);
    end
  endtask

  task automatic cmp_grants(input string tag, input int n, input int x0, input int i0,
                            input int x1, input int i1, input int x2, input int i2);
    int ex[3];
    int ei[3];
    ex = '{x0, x1, x2};
    ei = '{i0, i1, i2};
    chk({tag, "_count"}, g_x.size(), n);
    for (int k = 0; k < n && k < g_x.size(); k++) begin
      chk($sformatf("%s_cx%0d", tag, k), g_x[k], ex[k]);
      chk($sformatf("%s_idx%0d", tag, k), g_i[k], ei[k]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cx      = '0;
    cy      = '0;
    ssx     = 10'd160;
    ssy     = 10'd45;
    pkt_req = 4'b0000;

    // Reset values, then release mid-line: no island until a cx==0 budget load
    new_line();
    for (int x = 0; x <= 4; x++) step(x, 10);
    chk("reset_mode", mode_log[4], M_CTRL);
    chk("reset_grant", int'(pkt_grant), 0);
    chk("reset_sel", int'(pkt_sel), 0);
    chk("reset_sub", int'(sub_count), 0);
    rst_n   = 1'b1;
    pkt_req = 4'b1011;
    run_range(10, 5, LINE - 1, -1);
    cmp_line("midline_release_mode");
    cmp_grants("midline_release", 0, 0, 0, 0, 0, 0, 0);

    // Three requesters held over two lines
    new_line();
    run_range(11, 0, LINE - 1, -1);
    exp_island(3);
    cmp_line("multi_line1_mode");
`ifdef HDMI_SCHED_RR_EN
    cmp_grants("rr_line1", 3, 20, 0, 52, 1, 84, 3);
    chk("rr_sel_slot2", sel_log[60], 1);
`else
    cmp_grants("fixed_line1", 3, 20, 0, 52, 0, 84, 0);
    chk("fixed_sel_slot2", sel_log[60], 0);
`endif
    new_line();
    run_range(12, 0, LINE - 1, -1);
    exp_island(3);
    cmp_line("multi_line2_mode");
`ifdef HDMI_SCHED_RR_EN
    cmp_grants("rr_line2", 3, 20, 0, 52, 1, 84, 3);
`else
    cmp_grants("fixed_line2", 3, 20, 0, 52, 0, 84, 0);
`endif

    // Single requester on a blanking line
    pkt_req = 4'b0001;
    new_line();
    run_range(10, 0, LINE - 1, -1);
    exp_island(3);
    cmp_line("blank_island_mode");
    cmp_grants("blank_island", 3, 20, 0, 52, 0, 84, 0);
    chk("sub_first", sub_log[20], 0);
    chk("sub_last", sub_log[51], 31);
    chk("sub_wrap", sub_log[52], 0);
    chk("sub_mid", sub_log[100], 16);
    chk("sel_pkt", sel_log[30], 0);

    // Active line: island plus video periods
    new_line();
    run_range(100, 0, LINE - 1, -1);
    exp_island(3);
    fill(150, 157, M_VP);
    fill(158, 159, M_VG);
    fill(160, LINE - 1, M_V);
    cmp_line("active_line_mode");
    cmp_grants("active_line", 3, 20, 0, 52, 0, 84, 0);

    // Request dropped mid-packet: one packet, trailing guard at 52..53
    new_line();
    pkt_req = 4'b0001;
    run_range(10, 0, LINE - 1, 30);
    exp_island(1);
    cmp_line("drop_mode");
    cmp_grants("drop", 1, 20, 0, 0, 0, 0, 0);
    chk("drop_guard52", mode_log[52], M_DIG);
    chk("drop_ctrl54", mode_log[54], M_CTRL);

    // Narrow blanking: budget 0
    pkt_req = 4'b1111;
    ssx     = 10'd60;
    new_line();
    run_range(10, 0, LINE - 1, -1);
    cmp_line("narrow_blank_mode");
    cmp_grants("narrow_blank", 0, 0, 0, 0, 0, 0, 0);
    new_line();
    run_range(100, 0, LINE - 1, -1);
    fill(50, 57, M_VP);
    fill(58, 59, M_VG);
    fill(60, LINE - 1, M_V);
    cmp_line("narrow_active_mode");
    cmp_grants("narrow_active", 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted on packet pixel 15
    ssx     = 10'd160;
    pkt_req = 4'b0010;
    new_line();
    run_range(10, 0, 35, -1);
    chk("pre_reset_sub", sub_log[35], 15);
    chk("pre_reset_sel", sel_log[35], 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_mode", int'(mode), M_CTRL);
    chk("async_reset_sub", int'(sub_count), 0);
    chk("async_reset_sel", int'(pkt_sel), 0);
    chk("async_reset_grant", int'(pkt_grant), 0);
    run_range(10, 36, 38, -1);
    rst_n = 1'b1;
    run_range(10, 39, LINE - 1, -1);
    fill(10, 17, M_DIP);
    fill(18, 19, M_DIG);
    fill(20, 35, M_DIK);
    cmp_line("reset_line_mode");
    cmp_grants("reset_line", 1, 20, 1, 0, 0, 0, 0);
    new_line();
    run_range(11, 0, LINE - 1, -1);
    exp_island(3);
    cmp_line("after_reset_mode");
    cmp_grants("after_reset", 3, 20, 1, 52, 1, 84, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
